// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller: one outstanding access, byte-lane steering, load capture.
// Optional macro LSU_MISALIGN_TRAP_EN rejects misaligned halfword/word accesses instead of aligning.
module lsu_mem_ctrl #(
    parameter int unsigned D_WIDTH = 32,
    parameter int unsigned A_WIDTH = 32,
    parameter int unsigned RAM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [2:0]         req_funct3,
    input  logic [A_WIDTH-1:0] req_addr,
    input  logic [D_WIDTH-1:0] req_wdata,
    output logic               mem_en,
    output logic               mem_we,
    output logic [A_WIDTH-3:0] mem_addr,
    output logic [3:0]         mem_be,
    output logic [D_WIDTH-1:0] mem_wdata,
    input  logic [D_WIDTH-1:0] mem_rdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [D_WIDTH-1:0] rsp_ramout,
    output logic [2:0]         rsp_addrmode,
    output logic [1:0]         rsp_selectbits,
    output logic               rsp_err
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e             state_q, state_d;
    logic               we_q, we_d;
    logic [2:0]         f3_q, f3_d;
    logic [A_WIDTH-3:0] waddr_q, waddr_d;
    logic [1:0]         sel_q, sel_d;
    logic [D_WIDTH-1:0] wdata_q, wdata_d;
    logic [D_WIDTH-1:0] ramout_q, ramout_d;
    logic               err_q, err_d;
    logic [1:0]         cnt_q, cnt_d;

    logic               req_bad, req_mis, req_rej;
    logic [1:0]         req_sel;
    logic [3:0]         be_lanes;
    logic [D_WIDTH-1:0] wdata_lanes;

    // Request decode: funct3 legality, misalignment and the lane offset to latch.
    always_comb begin
        req_bad = req_we ? (req_funct3 > 3'b010)
                         : (req_funct3 == 3'b011 || req_funct3 == 3'b110 ||
                            req_funct3 == 3'b111);
        req_sel = req_addr[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
        req_mis = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                  ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        req_mis = 1'b0;
        if (!req_bad) begin
            case (req_funct3[1:0])
                2'b01:   req_sel = {req_addr[1], 1'b0};
                2'b10:   req_sel = 2'b00;
                default: req_sel = req_addr[1:0];
            endcase
        end
`endif
        req_rej = req_bad | req_mis;
    end

    always_comb begin
        be_lanes    = 4'b1111;
        wdata_lanes = wdata_q;
        if (we_q) begin
            case (f3_q[1:0])
                2'b00:   be_lanes = 4'b0001 << sel_q;
                2'b01:   be_lanes = 4'b0011 << sel_q;
                default: be_lanes = 4'b1111;
            endcase
        end
        case (f3_q[1:0])
            2'b00:   wdata_lanes = {4{wdata_q[7:0]}};
            2'b01:   wdata_lanes = {2{wdata_q[15:0]}};
            default: wdata_lanes = wdata_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        f3_d     = f3_q;
        waddr_d  = waddr_q;
        sel_d    = sel_q;
        wdata_d  = wdata_q;
        ramout_d = ramout_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d     = req_we;
                    f3_d     = req_funct3;
                    waddr_d  = req_addr[A_WIDTH-1:2];
                    sel_d    = req_sel;
                    wdata_d  = req_wdata;
                    ramout_d = '0;
                    err_d    = req_rej;
                    cnt_d    = 2'd0;
                    state_d  = req_rej ? StResp : StIssue;
                end
            end
            StIssue: begin
                cnt_d   = 2'd0;
                state_d = we_q ? StResp : StWait;
            end
            StWait: begin
                if (cnt_q == 2'(RAM_LAT - 1)) begin
                    ramout_d = mem_rdata;
                    state_d  = StResp;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            StResp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            f3_q     <= 3'b000;
            waddr_q  <= '0;
            sel_q    <= 2'b00;
            wdata_q  <= '0;
            ramout_q <= '0;
            err_q    <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            f3_q     <= f3_d;
            waddr_q  <= waddr_d;
            sel_q    <= sel_d;
            wdata_q  <= wdata_d;
            ramout_q <= ramout_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    // Strobes decode from the state register so a reset in ISSUE drops them at once.
    always_comb begin
        req_ready      = (state_q == StIdle);
        mem_en         = (state_q == StIssue);
        mem_we         = (state_q == StIssue) & we_q;
        mem_be         = (state_q == StIssue) ? be_lanes : 4'b0000;
        mem_addr       = waddr_q;
        mem_wdata      = wdata_lanes;
        rsp_valid      = (state_q == StResp);
        rsp_ramout     = ramout_q;
        rsp_addrmode   = f3_q;
        rsp_selectbits = sel_q;
        rsp_err        = (state_q == StResp) & err_q;
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized bench for lsu_mem_ctrl against a request-level model and a word-array RAM.
module tb_lsu_mem_ctrl;

    localparam int RAM_LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        mem_en, mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_ramout;
    logic [2:0]  rsp_addrmode;
    logic [1:0]  rsp_selectbits;
    logic        rsp_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] ref_mem [256];
    logic [31:0] ram [256];
    logic [31:0] rd_pipe [RAM_LAT];
    logic        ram_init;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.D_WIDTH(32), .A_WIDTH(32), .RAM_LAT(RAM_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ramout(rsp_ramout),
        .rsp_addrmode(rsp_addrmode), .rsp_selectbits(rsp_selectbits), .rsp_err(rsp_err)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'(i) * 32'h9E3779B1 + 32'h01234567;
    endfunction

    // RAM with RAM_LAT-deep read pipeline; stale slots carry a marker pattern.
    assign mem_rdata = rd_pipe[RAM_LAT-1];
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
        end else if (mem_en && mem_we) begin
            for (int i = 0; i < 4; i++)
                if (mem_be[i]) ram[mem_addr[7:0]][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
        rd_pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr[7:0]] : 32'h5EE0_5EE0;
        for (int i = 1; i < RAM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq(tag, {req_ready, mem_en, mem_we, rsp_valid, rsp_err, mem_be,
                       rsp_addrmode, rsp_selectbits}, {1'b1, 13'd0});
        check_eq({tag, "_data"}, {mem_addr, mem_wdata, rsp_ramout}, 64'd0);
    endtask

    task automatic drive_junk();
        req_valid  = 1'($urandom_range(0, 1));
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
    endtask

    task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
    endtask

    // Caller is just past a negedge with the DUT idle; returns in the same situation.
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int hold);
        logic        bad, mis, err;
        int          nbytes, o, off, lat, seen;
        logic [3:0]  be;
        logic [31:0] wexp, rexp;
        logic [7:0]  widx;

        bad    = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
        nbytes = 1 << f3[1:0];
        o      = int'(addr[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
        mis = !bad && ((o % nbytes) != 0);
        off = o;
`else
        mis = 1'b0;
        off = bad ? o : o - (o % nbytes);
`endif
        err  = bad | mis;
        be   = we ? 4'(((1 << nbytes) - 1) << off) : 4'hF;
        wexp = (nbytes == 1) ? 32'(wd[7:0]) * 32'h0101_0101 :
               (nbytes == 2) ? 32'(wd[15:0]) * 32'h0001_0001 : wd;
        widx = addr[9:2];
        rexp = (we || err) ? 32'd0 : ref_mem[widx];
        if (we && !err)
            for (int i = 0; i < 4; i++) if (be[i]) ref_mem[widx][8*i +: 8] = wexp[8*i +: 8];
        lat = err ? 1 : (we ? 2 : RAM_LAT + 2);

        check_eq("req_ready_idle", req_ready, 1);
        rsp_ready = 1'b0;
        drive_req(we, f3, addr, wd);
        @(negedge clk);
        seen = 0;
        for (int k = 1; k <= 20; k++) begin
            check_eq("req_ready_busy", req_ready, 0);
            if (k == 1 && !err) begin
                check_eq("issue_en", mem_en, 1);
                check_eq("issue_we", mem_we, we);
                check_eq("issue_addr", {2'b00, mem_addr}, addr >> 2);
                check_eq("issue_be", mem_be, be);
                if (we) check_eq("issue_wdata", mem_wdata, wexp);
            end else begin
                check_eq("strobes_off", {mem_en, mem_we, mem_be}, 0);
            end
            if (rsp_valid) begin
                seen = k;
                break;
            end
            drive_junk();
            @(negedge clk);
        end
        check_eq("rsp_latency", seen, lat);
        check_eq("rsp_ramout", rsp_ramout, rexp);
        check_eq("rsp_fields", {rsp_err, rsp_addrmode, rsp_selectbits},
                 {err, f3, 2'(off)});
        for (int h = 0; h < hold; h++) begin
            drive_junk();
            @(negedge clk);
            check_eq("rsp_hold", {req_ready, rsp_valid, rsp_err, rsp_addrmode,
                                  rsp_selectbits, rsp_ramout},
                     {1'b0, 1'b1, err, f3, 2'(off), rexp});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check_eq("back_to_idle", {req_ready, rsp_valid}, 2'b10);
    endtask

    initial begin
        logic [31:0] a, d;
        rst = 1'b1;
        ram_init = 1'b1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_funct3 = 3'd0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        #3;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        ram_init = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("after_reset");

        run_txn(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0);
        run_txn(1'b0, 3'b010, 32'h100, 32'h0, 0);
        run_txn(1'b1, 3'b000, 32'h203, 32'h0000_00A5, 0);
        run_txn(1'b0, 3'b001, 32'h102, 32'h0, 3);
        run_txn(1'b1, 3'b010, 32'h101, 32'h1357_9BDF, 1);
        run_txn(1'b0, 3'b111, 32'h104, 32'h0, 0);
        run_txn(1'b0, 3'b101, 32'h203, 32'h0, 2);

        // Reset during WAIT of a load: response must be discarded.
        drive_req(1'b0, 3'b010, 32'h140, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_in_wait");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < RAM_LAT + 3; i++) begin
            @(negedge clk);
            check_eq("no_rsp_after_rst", {req_ready, rsp_valid}, 2'b10);
        end
        run_txn(1'b0, 3'b010, 32'h140, 32'h0, 0);

        // Reset during ISSUE of a store: the write must not reach RAM.
        drive_req(1'b1, 3'b010, 32'h144, 32'hCAFE_F00D);
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("issue_before_rst", mem_en, 1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_in_issue");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_txn(1'b0, 3'b010, 32'h144, 32'h0, 0);

        for (int t = 0; t < 200; t++) begin
            a = 32'($urandom_range(0, 1023));
            d = $urandom;
            run_txn(1'($urandom), 3'($urandom), a, d, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
